// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: mid-bit sampling from a b_tick stream, framing/parity error pulses.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data and stop bits.
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic [2:0]           dbg_state_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

    // Line synchronizer and falling-edge detector
    logic       rx_meta_q;
    logic       rx_sync_q;
    logic       rx_prev_q;
    logic [1:0] sync_vld_q;
    logic       fall_edge;

    // The previous-level flop only follows the line once the synchronizer holds a real
    // sample, so a line already low when reset releases never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            sync_vld_q <= 2'b00;
            rx_prev_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            rx_prev_q  <= sync_vld_q[1] & rx_sync_q;
        end
    end

    assign fall_edge = rx_prev_q & ~rx_sync_q;

    // Frame FSM
    state_t                 state_q;
    logic [TW-1:0]          tick_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic                   busy_q;
    logic                   stop_pend_q;
    logic                   stop_bit_q;
    logic                   par_bad;

    assign shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;
    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            stop_bit_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
`endif
        end else begin
            stop_pend_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fall_edge) begin
                        state_q <= ST_START;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (b_tick) begin
                        if (tick_q == TICK_HALF) begin
                            tick_q <= '0;
                            bit_q  <= '0;
                            if (!rx_sync_q) begin
                                state_q <= ST_DATA;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (b_tick) begin
                        if (tick_q == TICK_LAST) begin
                            shift_q <= shift_d;
                            tick_q  <= '0;
                            if (bit_q == BIT_LAST) begin
                                bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (b_tick) begin
                        if (tick_q == TICK_LAST) begin
                            par_bad_q <= (^shift_q) ^ rx_sync_q;
                            tick_q    <= '0;
                            state_q   <= ST_STOP;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (b_tick) begin
                        if (tick_q == TICK_LAST) begin
                            stop_bit_q  <= rx_sync_q;
                            stop_pend_q <= 1'b1;
                            tick_q      <= '0;
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    tick_q  <= '0;
                    bit_q   <= '0;
                end
            endcase
        end
    end

    // Result pipeline: the stop sample is judged one clk after capture and the
    // outputs register one clk later, so the FSM is already free in IDLE meanwhile.
    logic                 fin_pend_q;
    logic                 fin_ok_q;
    logic                 fin_ferr_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_done_q;
    logic                 frame_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_pend_q  <= 1'b0;
            fin_ok_q    <= 1'b0;
            fin_ferr_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            fin_pend_q  <= stop_pend_q;
            fin_ok_q    <= stop_bit_q & ~par_bad;
            fin_ferr_q  <= ~stop_bit_q;
            rx_done_q   <= fin_pend_q & fin_ok_q;
            frame_err_q <= fin_pend_q & fin_ferr_q;
            if (fin_pend_q && fin_ok_q) begin
                rx_data_q <= shift_q;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic fin_perr_q;
    logic parity_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_perr_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            fin_perr_q   <= par_bad_q;
            parity_err_q <= fin_pend_q & fin_perr_q;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data     = rx_data_q;
    assign rx_done     = rx_done_q;
    assign frame_err   = frame_err_q;
    assign rx_busy     = busy_q;
    assign dbg_state_o = state_q;

endmodule
